// File: rtl/opcode_sequencer_pkg.sv
// Opcode sequencer shared ISA definitions: opcode classes,
// field positions, sequencer control sub-ops and FSM states.
package opcode_sequencer_pkg;

  localparam int INSTR_W = 16;

  localparam int CLS_HI    = 15;
  localparam int CLS_LO    = 14;
  localparam int STORE_BIT = 8;
  localparam int SUB_HI    = 7;
  localparam int SUB_LO    = 6;

  typedef enum logic [1:0] {
    CLS_LOAD = 2'b00,
    CLS_ALU2 = 2'b01,
    CLS_ALU1 = 2'b10,
    CLS_MISC = 2'b11
  } op_class_e;

  typedef enum logic [1:0] {
    CTL_END     = 2'b00,
    CTL_WAIT    = 2'b01,
    CTL_SETLOOP = 2'b10,
    CTL_LOOP    = 2'b11
  } ctl_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WAIT = 2'b10
  } seq_state_e;

  // MISC without the store bit is a core no-op,
  // so the sequencer claims it for itself.
  function automatic logic is_ctrl(
    input logic [INSTR_W-1:0] i
  );
    return (op_class_e'(i[CLS_HI:CLS_LO]) == CLS_MISC)
        && !i[STORE_BIT];
  endfunction

  function automatic ctl_op_e ctl_op(
    input logic [INSTR_W-1:0] i
  );
    return ctl_op_e'(i[SUB_HI:SUB_LO]);
  endfunction

endpackage

// File: rtl/opcode_sequencer_prog_mem.sv
// Program store: DEPTH x DW register file, one write port,
// one asynchronous read port, contents not reset.
module opcode_sequencer_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: runs a stored program once per start,
// issuing opcode/execute to the cores; ctrl ops stay local.
module opcode_sequencer
  import opcode_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int LOOP_W     = 6,
  parameter int WAIT_W     = 4,
  localparam int PC_W      = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic [INSTR_W-1:0] opcode,
  output logic               execute,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc
);

  seq_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [LOOP_W-1:0]   loop_q, loop_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [INSTR_W-1:0]  op_q, op_d;
  logic                exec_q, exec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                last_q, last_d;
  logic [INSTR_W-1:0]  instr;
  logic [WAIT_W-1:0]   wait_n;
  logic                ctrl;
  logic                end_now;
  logic                step;
  logic                last_addr;

  opcode_sequencer_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (PC_W),
    .DW    (INSTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (prog_we && (state_q == S_IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (instr)
  );

  assign ctrl      = is_ctrl(instr);
  assign wait_n    = instr[WAIT_W-1:0];
  assign last_addr = (pc_q == PC_W'(PROG_DEPTH - 1));
  // last_q: the final address has been consumed,
  // so the next RUN cycle is an implicit END.
  assign end_now   = last_q
                  || (ctrl && ctl_op(instr) == CTL_END);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    loop_d  = loop_q;
    wait_d  = wait_q;
    op_d    = op_q;
    exec_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    last_d  = last_q;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          busy_d  = 1'b1;
          last_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (end_now) begin
          state_d = S_IDLE;
          pc_d    = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          last_d  = 1'b0;
        end else if (!ctrl) begin
          op_d   = instr;
          exec_d = 1'b1;
          step   = 1'b1;
        end else begin
          step = 1'b1;
          unique case (ctl_op(instr))
            CTL_WAIT: begin
              wait_d = wait_n;
              // The WAIT cycle itself is already one
              // idle cycle, so only n>1 parks in WAIT.
              if (wait_n > WAIT_W'(1))
                state_d = S_WAIT;
            end
            CTL_SETLOOP: begin
              loop_d = instr[LOOP_W-1:0];
            end
            CTL_LOOP: begin
              if (loop_q != '0) begin
                loop_d = loop_q - 1'b1;
                pc_d   = instr[PC_W-1:0];
                step   = 1'b0;
              end
            end
            default: step = 1'b1;
          endcase
        end
        if (step) begin
          if (last_addr) last_d = 1'b1;
          else           pc_d   = pc_q + 1'b1;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= WAIT_W'(2))
          state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      loop_q  <= '0;
      wait_q  <= '0;
      op_q    <= '0;
      exec_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      loop_q  <= loop_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      exec_q  <= exec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign opcode  = op_q;
  assign execute = exec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pc      = pc_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed bench for opcode_sequencer: small programs with
// hand-computed execute/done cycle numbers.
module tb_opcode_sequencer;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic [15:0] opcode;
  logic        execute;
  logic        busy;
  logic        done;
  logic [3:0]  pc;

  int n_chk;
  int n_fail;
  int exec_cyc[$];
  logic [15:0] exec_op[$];
  int done_cyc;
  int done_cnt;

  opcode_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .opcode    (opcode),
    .execute   (execute),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a[3:0];
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  function automatic int cyc(input int i);
    return (i < exec_cyc.size()) ? exec_cyc[i] : -1;
  endfunction

  function automatic logic [15:0] opv(input int i);
    return (i < exec_op.size()) ? exec_op[i] : 16'hxxxx;
  endfunction

  // Cycle 0 = start high; cycle numbers match the
  // timing the design promises after start.
  task automatic run_prog(input int budget, input int poke);
    exec_cyc.delete();
    exec_op.delete();
    done_cyc = -1;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_c1", {31'd0, busy}, 1);
    for (int c = 2; c < budget && done_cyc < 0; c++) begin
      if (c == poke) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd2;
        prog_data = 16'hFFFF;
      end
      tick();
      start   = 1'b0;
      prog_we = 1'b0;
      if (execute) begin
        exec_cyc.push_back(c);
        exec_op.push_back(opcode);
      end
      if (done) begin
        done_cyc = c;
        done_cnt++;
        chk("exec_at_done", {31'd0, execute}, 0);
        chk("busy_at_done", {31'd0, busy}, 0);
        chk("pc_at_done", {28'd0, pc}, 0);
      end
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) done_cnt++;
      chk("idle_quiet", {30'd0, execute, busy}, 0);
    end
    chk("done_once", done_cnt, 1);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    #12;
    chk("rst_exec", {31'd0, execute}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pc", {28'd0, pc}, 0);
    chk("rst_op", {16'd0, opcode}, 0);
    rst_n = 1'b1;
    tick();

    // 1: single core op then END
    wr(0, 16'h0105);
    wr(1, 16'hC000);
    run_prog(30, -1);
    chk("t1_n", exec_cyc.size(), 1);
    chk("t1_cyc", cyc(0), 2);
    chk("t1_op", {16'd0, opv(0)}, 16'h0105);
    chk("t1_done", done_cyc, 3);

    // 2: WAIT 3 between two core ops
    wr(0, 16'h4123);
    wr(1, 16'hC043);
    wr(2, 16'h8456);
    wr(3, 16'hC000);
    run_prog(30, -1);
    chk("t2_n", exec_cyc.size(), 2);
    chk("t2_gap", cyc(1) - cyc(0) - 1, 3);
    chk("t2_op0", {16'd0, opv(0)}, 16'h4123);
    chk("t2_op1", {16'd0, opv(1)}, 16'h8456);
    chk("t2_done", done_cyc, 7);

    // 3: SETLOOP 2 around one body op
    wr(0, 16'hC082);
    wr(1, 16'h1234);
    wr(2, 16'hC0C1);
    wr(3, 16'hC000);
    run_prog(40, -1);
    chk("t3_n", exec_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_op", {16'd0, opv(i)}, 16'h1234);
      chk("t3_cyc", cyc(i), 3 + 2 * i);
    end
    chk("t3_done", done_cyc, 9);

    // 4: full memory of core ops, implicit END
    for (int i = 0; i < 16; i++)
      wr(i, 16'h0100 + 16'(i));
    run_prog(40, -1);
    chk("t4_n", exec_cyc.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t4_cyc", cyc(i), i + 2);
      chk("t4_op", {16'd0, opv(i)}, 16'h0100 + i);
    end
    chk("t4_done", done_cyc, 18);

    // 5: write and start while busy are ignored
    wr(0, 16'h4001);
    wr(1, 16'hC043);
    wr(2, 16'h4002);
    wr(3, 16'hC000);
    run_prog(30, 4);
    chk("t5_n", exec_cyc.size(), 2);
    chk("t5_op1", {16'd0, opv(1)}, 16'h4002);
    chk("t5_done", done_cyc, 7);

    // 6: async reset while parked in WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_exec", {31'd0, execute}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_pc", {28'd0, pc}, 0);
    chk("t6_op", {16'd0, opcode}, 0);
    chk("t6_done", {31'd0, done}, 0);
    #2;
    rst_n = 1'b1;
    tick();
    run_prog(30, -1);
    chk("t6r_n", exec_cyc.size(), 2);
    chk("t6r_op0", {16'd0, opv(0)}, 16'h4001);
    chk("t6r_op1", {16'd0, opv(1)}, 16'h4002);
    chk("t6r_done", done_cyc, 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
